// File: rtl/seg7_sequence_checker_if.sv
// Segment-bus monitor interface: sampled pattern and enable in, decoded digit,
// event pulses and saturating counters out.
interface seg7_sequence_checker_if #(
  parameter int CNT_W = 8
);
  logic             ena;
  logic [6:0]       seg_in;
  logic [3:0]       digit_out;
  logic             digit_valid;
  logic             new_digit;
  logic             seq_err;
  logic             invalid_err;
  logic [CNT_W-1:0] digit_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output ena, seg_in,
    input  digit_out, digit_valid, new_digit, seq_err, invalid_err,
           digit_count, err_count
  );

  modport slave (
    input  ena, seg_in,
    output digit_out, digit_valid, new_digit, seq_err, invalid_err,
           digit_count, err_count
  );
endinterface

// File: rtl/seg7_sequence_checker.sv
// Seven-segment receive monitor: debounces the segment bus, decodes accepted
// patterns to BCD, checks that digits advance by one modulo 10 and counts
// digits and errors with saturating counters.
module seg7_sequence_checker #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  seg7_sequence_checker_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

  // {valid, digit}; blank and unknown patterns both report not-valid
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = 5'h10;
      7'h06:   decode = 5'h11;
      7'h5B:   decode = 5'h12;
      7'h4F:   decode = 5'h13;
      7'h66:   decode = 5'h14;
      7'h6D:   decode = 5'h15;
      7'h7D:   decode = 5'h16;
      7'h07:   decode = 5'h17;
      7'h7F:   decode = 5'h18;
      7'h6F:   decode = 5'h19;
      default: decode = 5'h00;
    endcase
  endfunction

  function automatic logic [3:0] next_digit(input logic [3:0] d);
    next_digit = (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [6:0]       samp_q, samp_d;
  logic             smp_vld_q, smp_vld_d;
  logic [1:0]       state_q, state_d;
  logic             home_trk_q, home_trk_d;
  logic [6:0]       cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [6:0]       acc_q, acc_d;
  logic [3:0]       digit_q, digit_d;
  logic             dv_q, dv_d;
  logic             nd_q, nd_d;
  logic             se_q, se_d;
  logic             ie_q, ie_d;
  logic [3:0]       pred_q, pred_d;
  logic             pred_vld_q, pred_vld_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [4:0]       dec;
  logic             accept;

  // Sample register, settling FSM and acceptance side effects
  always_comb begin
    samp_d     = samp_q;
    smp_vld_d  = smp_vld_q;
    state_d    = state_q;
    home_trk_d = home_trk_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    digit_d    = digit_q;
    dv_d       = dv_q;
    nd_d       = 1'b0;
    se_d       = 1'b0;
    ie_d       = 1'b0;
    pred_d     = pred_q;
    pred_vld_d = pred_vld_q;
    dcnt_d     = dcnt_q;
    ecnt_d     = ecnt_q;
    dec        = decode(samp_q);
    accept     = 1'b0;

    if (!bus.ena) begin
      // the held sample goes stale, so the next enabled cycle starts afresh
      smp_vld_d = 1'b0;
      cnt_d     = 4'd0;
    end else begin
      samp_d    = bus.seg_in;
      smp_vld_d = 1'b1;
      if (smp_vld_q) begin
        if (samp_q == acc_q) begin
          if (state_q == S_SETTLE) state_d = home_trk_q ? S_TRACK : S_IDLE;
          cnt_d = 4'd0;
        end else if (state_q == S_SETTLE && samp_q == cand_q && cnt_q != 4'd0) begin
          if (cnt_q + 4'd1 >= STABLE_N) accept = 1'b1;
          else                          cnt_d  = cnt_q + 4'd1;
        end else begin
          cand_d = samp_q;
          if (STABLE_N <= 4'd1) begin
            accept = 1'b1;
          end else begin
            cnt_d   = 4'd1;
            state_d = S_SETTLE;
          end
        end

        if (accept) begin
          state_d    = S_TRACK;
          home_trk_d = 1'b1;
          cnt_d      = 4'd0;
          acc_d      = samp_q;
          if (dec[4]) begin
            digit_d = dec[3:0];
            dv_d    = 1'b1;
            nd_d    = 1'b1;
            dcnt_d  = sat_inc(dcnt_q);
            if (pred_vld_q && dec[3:0] != next_digit(pred_q)) begin
              se_d   = 1'b1;
              ecnt_d = sat_inc(ecnt_q);
            end
            pred_d     = dec[3:0];
            pred_vld_d = 1'b1;
          end else begin
            dv_d       = 1'b0;
            pred_vld_d = 1'b0;
            if (samp_q != 7'h00) begin
              ie_d   = 1'b1;
              ecnt_d = sat_inc(ecnt_q);
            end
          end
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q     <= 7'h00;
      smp_vld_q  <= 1'b0;
      state_q    <= S_IDLE;
      home_trk_q <= 1'b0;
      cand_q     <= 7'h00;
      cnt_q      <= 4'd0;
      acc_q      <= 7'h00;
      digit_q    <= 4'd0;
      dv_q       <= 1'b0;
      nd_q       <= 1'b0;
      se_q       <= 1'b0;
      ie_q       <= 1'b0;
      pred_q     <= 4'd0;
      pred_vld_q <= 1'b0;
      dcnt_q     <= '0;
      ecnt_q     <= '0;
    end else begin
      samp_q     <= samp_d;
      smp_vld_q  <= smp_vld_d;
      state_q    <= state_d;
      home_trk_q <= home_trk_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      digit_q    <= digit_d;
      dv_q       <= dv_d;
      nd_q       <= nd_d;
      se_q       <= se_d;
      ie_q       <= ie_d;
      pred_q     <= pred_d;
      pred_vld_q <= pred_vld_d;
      dcnt_q     <= dcnt_d;
      ecnt_q     <= ecnt_d;
    end
  end

  assign bus.digit_out   = digit_q;
  assign bus.digit_valid = dv_q;
  assign bus.new_digit   = nd_q;
  assign bus.seq_err     = se_q;
  assign bus.invalid_err = ie_q;
  assign bus.digit_count = dcnt_q;
  assign bus.err_count   = ecnt_q;
endmodule

// File: tb/tb_seg7_sequence_checker.sv
// Bench for seg7_sequence_checker: directed scenarios plus randomized traffic,
// all compared with a run-length behavioural model of the segment monitor.
module tb_seg7_sequence_checker;
  localparam int S = 4;
  localparam logic [6:0] PAT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_sequence_checker_if #(.CNT_W(8)) bus ();
  seg7_sequence_checker_if #(.CNT_W(2)) bus2 ();

  seg7_sequence_checker #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  seg7_sequence_checker #(.STABLE_CYCLES(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;
  int p_nd, p_se, p_ie, p_both;

  // Behavioural model: a pattern is accepted once its current run of enabled
  // samples reaches S and it differs from the accepted pattern.
  logic [6:0] m_run_val, m_acc;
  int         m_run_len;
  logic [3:0] m_digit;
  logic       m_dv, m_nd, m_se, m_ie;
  int         m_dcnt, m_ecnt, m_pred;

  task automatic m_reset();
    m_run_val = 7'h00; m_run_len = 0; m_acc = 7'h00;
    m_digit = 4'd0; m_dv = 1'b0; m_nd = 1'b0; m_se = 1'b0; m_ie = 1'b0;
    m_dcnt = 0; m_ecnt = 0; m_pred = -1;
  endtask

  task automatic m_accept(input logic [6:0] p);
    int idx;
    idx = -1;
    for (int d = 0; d < 10; d++) if (PAT[d] == p) idx = d;
    if (idx >= 0) begin
      m_digit = 4'(idx);
      m_dv = 1'b1;
      m_nd = 1'b1;
      if (m_dcnt < 255) m_dcnt++;
      if (m_pred >= 0 && idx != (m_pred + 1) % 10) begin
        m_se = 1'b1;
        if (m_ecnt < 255) m_ecnt++;
      end
      m_pred = idx;
    end else begin
      m_dv = 1'b0;
      m_pred = -1;
      if (p != 7'h00) begin
        m_ie = 1'b1;
        if (m_ecnt < 255) m_ecnt++;
      end
    end
    m_acc = p;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        m_nd = 1'b0; m_se = 1'b0; m_ie = 1'b0;
        if (bus.ena) begin
          if (m_run_len >= S && m_run_val != m_acc) m_accept(m_run_val);
          if (m_run_len > 0 && bus.seg_in == m_run_val) m_run_len++;
          else begin
            m_run_val = bus.seg_in;
            m_run_len = 1;
          end
        end else begin
          m_run_len = 0;
        end
      end
    end
  end

  function automatic logic [23:0] dut_vec();
    return {bus.digit_out, bus.digit_valid, bus.new_digit, bus.seq_err,
            bus.invalid_err, bus.digit_count, bus.err_count};
  endfunction

  function automatic logic [23:0] mdl_vec();
    return {m_digit, m_dv, m_nd, m_se, m_ie, 8'(m_dcnt), 8'(m_ecnt)};
  endfunction

  task automatic clr_pulses();
    p_nd = 0; p_se = 0; p_ie = 0; p_both = 0;
  endtask

  // Drive a pattern for n cycles, comparing the DUT with the model each cycle
  task automatic run(input logic [6:0] p, input int n);
    bus.seg_in = p;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL model_cmp t=%0t got %h expected %h", $time, dut_vec(), mdl_vec());
      end
      if (bus.new_digit === 1'b1) p_nd++;
      if (bus.seq_err === 1'b1) p_se++;
      if (bus.invalid_err === 1'b1) p_ie++;
      if (bus.new_digit === 1'b1 && bus.seq_err === 1'b1) p_both++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.ena = 1'b0; bus.seg_in = 7'h00; bus2.ena = 1'b0; bus2.seg_in = 7'h00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dut_vec() !== 24'h0) begin
      errors++; $display("FAIL reset_main got %h expected 000000", dut_vec());
    end
    checks++;
    if ({bus2.digit_out, bus2.digit_valid, bus2.new_digit, bus2.seq_err, bus2.invalid_err,
         bus2.digit_count, bus2.err_count} !== 12'h0) begin
      errors++; $display("FAIL reset_sat got nonzero outputs, expected all zero");
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_digit();
    clr_pulses();
    bus.ena = 1'b1;
    run(PAT[0], 4);
    checks++;
    if (p_nd !== 0) begin errors++; $display("FAIL first_early got %0d pulses expected 0", p_nd); end
    run(PAT[0], 1);
    checks++;
    if ({bus.digit_out, bus.digit_valid, bus.new_digit, bus.seq_err, bus.digit_count} !== {4'd0, 1'b1, 1'b1, 1'b0, 8'd1}) begin
      errors++; $display("FAIL first_accept got dig=%0d v=%b nd=%b se=%b cnt=%0d expected 0 1 1 0 1",
                         bus.digit_out, bus.digit_valid, bus.new_digit, bus.seq_err, bus.digit_count);
    end
    run(PAT[0], 1);
    checks++;
    if (bus.new_digit !== 1'b0) begin errors++; $display("FAIL first_pulse_width got %b expected 0", bus.new_digit); end
  endtask

  task automatic test_full_sequence();
    do_reset();
    clr_pulses();
    for (int d = 0; d <= 10; d++) run(PAT[d % 10], 10);
    checks++;
    if (p_nd !== 11 || p_se !== 0) begin
      errors++; $display("FAIL full_seq_pulses got nd=%0d se=%0d expected 11 0", p_nd, p_se);
    end
    checks++;
    if (bus.digit_count !== 8'd11 || bus.err_count !== 8'd0) begin
      errors++; $display("FAIL full_seq_counts got dc=%0d ec=%0d expected 11 0", bus.digit_count, bus.err_count);
    end
  endtask

  task automatic test_glitch_skip();
    clr_pulses();
    run(PAT[1], 3);
    run(PAT[0], 6);
    checks++;
    if (p_nd !== 0 || bus.digit_out !== 4'd0) begin
      errors++; $display("FAIL glitch got nd=%0d dig=%0d expected 0 0", p_nd, bus.digit_out);
    end
    run(PAT[2], 8);
    checks++;
    if (p_both !== 1 || bus.digit_out !== 4'd2 || bus.err_count !== 8'd1) begin
      errors++; $display("FAIL skip got both=%0d dig=%0d ec=%0d expected 1 2 1", p_both, bus.digit_out, bus.err_count);
    end
  endtask

  task automatic test_invalid_blank();
    clr_pulses();
    run(7'h49, 8);
    checks++;
    if (p_ie !== 1 || bus.digit_valid !== 1'b0 || bus.digit_out !== 4'd2 || bus.err_count !== 8'd2) begin
      errors++; $display("FAIL invalid got ie=%0d v=%b dig=%0d ec=%0d expected 1 0 2 2",
                         p_ie, bus.digit_valid, bus.digit_out, bus.err_count);
    end
    clr_pulses();
    run(PAT[3], 8);
    checks++;
    if (p_nd !== 1 || p_se !== 0 || bus.digit_out !== 4'd3) begin
      errors++; $display("FAIL after_invalid got nd=%0d se=%0d dig=%0d expected 1 0 3", p_nd, p_se, bus.digit_out);
    end
    clr_pulses();
    run(7'h00, 8);
    checks++;
    if (p_nd + p_se + p_ie !== 0 || bus.digit_valid !== 1'b0 || bus.digit_out !== 4'd3) begin
      errors++; $display("FAIL blank got pulses=%0d v=%b dig=%0d expected 0 0 3",
                         p_nd + p_se + p_ie, bus.digit_valid, bus.digit_out);
    end
    run(PAT[5], 8);
    checks++;
    if (p_nd !== 1 || p_se !== 0 || bus.err_count !== 8'd2) begin
      errors++; $display("FAIL after_blank got nd=%0d se=%0d ec=%0d expected 1 0 2", p_nd, p_se, bus.err_count);
    end
  endtask

  task automatic test_enable();
    logic [23:0] frozen;
    frozen = mdl_vec();
    clr_pulses();
    bus.ena = 1'b0;
    for (int i = 0; i < 20; i++) run(PAT[$urandom_range(0, 9)], 1);
    checks++;
    if (dut_vec() !== frozen || p_nd + p_se + p_ie !== 0) begin
      errors++; $display("FAIL ena_freeze got %h pulses=%0d expected %h 0", dut_vec(), p_nd + p_se + p_ie, frozen);
    end
    bus.ena = 1'b1;
    run(PAT[6], 10);
    checks++;
    if (p_nd !== 1 || p_se !== 0 || bus.digit_out !== 4'd6) begin
      errors++; $display("FAIL ena_resume got nd=%0d se=%0d dig=%0d expected 1 0 6", p_nd, p_se, bus.digit_out);
    end
  endtask

  task automatic test_reset_mid_settle();
    run(PAT[7], 2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 24'h0) begin
      errors++; $display("FAIL reset_async got %h expected 000000", dut_vec());
    end
    bus.seg_in = 7'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clr_pulses();
    run(7'h00, 10);
    checks++;
    if (p_nd + p_se + p_ie !== 0 || bus.digit_count !== 8'd0 || bus.digit_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release got pulses=%0d dc=%0d v=%b expected 0 0 0",
                         p_nd + p_se + p_ie, bus.digit_count, bus.digit_valid);
    end
  endtask

  task automatic test_back_to_back();
    clr_pulses();
    for (int d = 0; d < 4; d++) run(PAT[d], S);
    run(PAT[3], 4);
    checks++;
    if (p_nd !== 4 || p_se !== 0 || bus.digit_out !== 4'd3) begin
      errors++; $display("FAIL back_to_back got nd=%0d se=%0d dig=%0d expected 4 0 3", p_nd, p_se, bus.digit_out);
    end
  endtask

  task automatic test_saturation();
    logic [6:0] pats [5];
    int ie_cnt;
    pats = '{7'h49, 7'h01, 7'h49, 7'h01, 7'h49};
    ie_cnt = 0;
    bus2.ena = 1'b1;
    bus2.seg_in = 7'h00;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus2.seg_in = pats[i];
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (bus2.invalid_err === 1'b1) ie_cnt++;
      end
    end
    checks++;
    if (ie_cnt !== 5 || bus2.err_count !== 2'd3) begin
      errors++; $display("FAIL saturation got ie=%0d ec=%0d expected 5 3", ie_cnt, bus2.err_count);
    end
    bus2.ena = 1'b0;
  endtask

  task automatic test_random();
    int cur, r, len;
    logic [6:0] p;
    do_reset();
    bus.ena = 1'b1;
    cur = 0;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin cur = (cur + 1) % 10; p = PAT[cur]; end
      else if (r < 75) begin cur = $urandom_range(0, 9); p = PAT[cur]; end
      else if (r < 85) p = 7'h00;
      else p = 7'($urandom);
      len = $urandom_range(1, 8);
      bus.ena = ($urandom_range(0, 9) != 0);
      clr_pulses();
      run(p, len);
      checks++;
      if (bus.seq_err === 1'b1 && bus.invalid_err === 1'b1) begin
        errors++; $display("FAIL err_exclusive got both high expected at most one");
      end
    end
    bus.ena = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first_digit();
    test_full_sequence();
    test_glitch_skip();
    test_invalid_blank();
    test_enable();
    test_reset_mid_settle();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_sequence_checker.md
# seg7_sequence_checker

Receive-side monitor for a seven-segment digit display bus. It samples a 7-bit segment pattern, accepts a pattern only after it has been stable for a programmable number of cycles, and decodes it back to a BCD digit. It also checks that successive digits advance by exactly one modulo 10, and counts digits and errors. It is the decoding end of the seconds-counter display path: it sits on the segment outputs of a counter or display driver, either as an on-chip self-check or as a bench-side checker.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive sampled cycles a pattern must hold before it is accepted. Legal range 1..15.
- `CNT_W`, default 8: width of the saturating digit and error counters.

- `clk`  in  1: sole clock; everything is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ena`  in  1: enable. Low freezes all state.
- `seg_in`  in  7: segment pattern, bit0=a .. bit6=g, active high. Asynchronous to the block's logic; sampled once per edge.
- `digit_out`  out  4: last accepted valid digit, 0..9.
- `digit_valid`  out  1: high while the currently accepted pattern is a valid digit.
- `new_digit`  out  1: one-cycle pulse when a valid digit is accepted.
- `seq_err`  out  1: one-cycle pulse when an accepted digit does not equal predecessor+1 mod 10.
- `invalid_err`  out  1: one-cycle pulse when an accepted non-blank pattern is not a digit.
- `digit_count`  out  CNT_W: number of valid digits accepted; saturates at all-ones.
- `err_count`  out  CNT_W: number of `seq_err` plus `invalid_err` events; saturates at all-ones.

## Operation
- **Digit encoding** (gfedcba): 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. 0x00 is "blank". Every other pattern is invalid.
- **State machine**
  - IDLE: after reset, no predecessor digit.
  - TRACK: an accepted pattern exists; a predecessor digit may or may not exist.
  - SETTLE: a candidate pattern differs from the accepted pattern and its stability count is running.
- **Accepted-pattern register**: resets to 0x00, so a blank bus after reset produces no event.
- **Settling**
  - A sampled pattern different from the accepted pattern starts SETTLE with that pattern as candidate.
  - Any sample differing from the candidate restarts SETTLE with the new candidate.
  - A sample equal to the accepted pattern returns to the previous state (IDLE or TRACK) with no event.
- **On acceptance of pattern P** (state goes to TRACK):
  - Valid digit D:
    - `digit_out`=D, `digit_valid`=1, `new_digit` pulses, `digit_count`+1.
    - If a predecessor exists and D != (pred+1) mod 10, `seq_err` pulses and `err_count`+1.
    - D becomes the predecessor. 9->0 is legal.
  - Blank: `digit_valid`=0, `digit_out` holds, no pulse, predecessor cleared.
  - Invalid: `digit_valid`=0, `digit_out` holds, `invalid_err` pulses, `err_count`+1, predecessor cleared.
- **`seq_err` and `invalid_err`**: never assert together. Each error event adds exactly 1 to `err_count`.
- **`ena` low**
  - No sampling; stability count cleared; state, registers and counters hold.
  - All pulse outputs low.
  - On `ena` high, settling restarts from a fresh sample.

## Timing
- **Reset values** (asynchronous on `rst_n` low): `digit_out`=0, `digit_valid`=0, `new_digit`=0, `seq_err`=0, `invalid_err`=0, `digit_count`=0, `err_count`=0, state IDLE, no predecessor.
- **Latency**: if `seg_in`=P (different from the accepted pattern) is sampled at edges k..k+STABLE_CYCLES-1, then the outputs and pulses update at edge k+STABLE_CYCLES.
  - Pulses are high for exactly one cycle after that edge.
  - With `STABLE_CYCLES`=1, acceptance happens at edge k+1.
- **Debounce**: a pattern held for fewer than `STABLE_CYCLES` samples produces no output change.
- **Back-to-back changes**: a new pattern may start settling in the same cycle a pulse is high. The minimum spacing between two acceptances is `STABLE_CYCLES` edges.
- **Reset mid-SETTLE**: the candidate is discarded and no pulse occurs.
- **Counter saturation**: counters stop at 2^CNT_W-1 and never wrap. Pulses still fire when saturated.

## Test plan
- **First digit**: reset, `ena`=1, `seg_in`=0x3F held 4 edges → at edge 4, `digit_out`=0, `digit_valid`=1, `new_digit` high 1 cycle, `seq_err`=0, `digit_count`=1.
- **Full sequence**: sequence 0,1,..,9,0 with each digit held 10 cycles → 11 `new_digit` pulses, `seq_err` never high, `digit_count`=11, `err_count`=0.
- **Glitch then skip**: after digit 0, apply 0x06 for 3 cycles, then back to 0x3F → no pulse, `digit_out`=0. Then apply 0x5B held → `new_digit`+`seq_err` on the same cycle, `digit_out`=2, `err_count`=1.
- **Invalid then blank**
  - 0x49 held → `invalid_err` pulse, `digit_valid`=0, `digit_out` unchanged, `err_count`+1.
  - Then 0x4F (3) → `new_digit`, no `seq_err`.
  - Then 0x00 → `digit_valid`=0, no pulse.
  - Then 0x6D (5) → no `seq_err`.
- **Enable and reset**: `ena` low for 20 cycles while `seg_in` changes → all outputs frozen, no pulses. Reset asserted at edge 2 of SETTLE → all outputs at reset values immediately and no pulse after release.
- **Saturation**: `CNT_W`=2, 5 invalid patterns → `err_count`=3 with 5 `invalid_err` pulses.
